branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor directly upstream of the branch evaluation stage. It holds a table of 2-bit saturating counters indexed by PC and produces the registered `branch_decision` that the evaluation stage compares against the actual outcome. It is trained by the resolved outcome (`branch_taken`, `flush`) that the evaluation stage returns, and it keeps saturating statistics counters for lookups and mispredictions.

## Interface
- `ENTRIES`, 64: number of table entries; power of two, minimum 4.
- `STAT_W`, 32: width of the statistics counters.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pred_valid` input 1: lookup request this cycle.
- `pred_pc` input 64: PC of the branch being looked up.
- `branch_decision` output 1: registered prediction (1 = taken).
- `decision_valid` output 1: `branch_decision` holds a fresh result for the request from the previous cycle.
- `upd_valid` input 1: resolved-branch training strobe.
- `upd_pc` input 64: PC of the resolved branch.
- `upd_taken` input 1: actual outcome, from the evaluation stage's `branch_taken`.
- `upd_mispredict` input 1: evaluation stage `flush` for this branch.
- `lookup_count` output STAT_W: number of accepted lookups.
- `mispredict_count` output STAT_W: number of updates that had `upd_mispredict=1`.

## Operation
- Index: `IDX_W = log2(ENTRIES)`; `idx = pc[IDX_W+1:2]`. PC bits [1:0] are ignored, and so are bits above the index (no tags, aliasing allowed).
- Counter states: SNT=00, WNT=01, WT=10, ST=11. The prediction is counter bit [1].
- Reset (`rst_n=0`, asynchronous):
  - every entry is set to WNT;
  - `branch_decision=0` and `decision_valid=0`;
  - both statistics counters are set to 0.
- Lookup: when `pred_valid=1`, the next edge latches `branch_decision` from entry idx(`pred_pc`) and sets `decision_valid=1`.
- No lookup: when `pred_valid=0`, `decision_valid` is 0 on the next edge and `branch_decision` holds its last value.
- Update: when `upd_valid=1`, entry idx(`upd_pc`) takes its new value on the edge.
  - Taken: the entry becomes min(c+1, ST).
  - Not taken: the entry becomes max(c-1, SNT).
  - Saturation is exact: no wrap from ST to SNT or from SNT to ST.
- Same-cycle bypass: if `pred_valid` and `upd_valid` are both 1 and the indices match, the prediction uses the post-update counter value.
- Different indices in the same cycle: the lookup and the update proceed independently.
- Statistics:
  - `lookup_count` increments on each `pred_valid=1` cycle;
  - `mispredict_count` increments on each cycle with `upd_valid=1` and `upd_mispredict=1`;
  - both saturate at all-ones and never wrap.
- `upd_mispredict` does not affect table training. It feeds statistics only.
- Inputs are never back-pressured. A lookup and an update are accepted every cycle.

## Timing
- Lookup latency is 1 cycle: request at edge N-1..N, and `branch_decision`/`decision_valid` are valid after edge N, aligned with the evaluation stage's sampling in cycle N.
- Update latency: the table write is visible to a lookup issued in the same cycle (bypass) and to all later lookups.
- Statistics outputs are registered and reflect events up to the previous edge.
- Reset mid-operation: all state clears immediately on `rst_n` falling, with no wait for a clock edge. The first lookup accepted after `rst_n` rises predicts not-taken (WNT).
- Back-to-back updates to the same index on consecutive cycles each move the counter by one step. Two taken updates starting from WNT end at ST.

## Structure
- `bp_pkg`:
  - counter typedef and the SNT/WNT/WT/ST constants;
  - the reset value WNT;
  - functions `bp_index(pc)` and `bp_next(c, taken)`.
- Sub-module `bp_sat_counter`: a parameterised STAT_W saturating incrementer with async active-low reset and an `inc` enable. It is instantiated twice, for lookups and for mispredictions.
- The table is a flop array so that async reset of all entries is possible. Do not infer RAM.

## Test plan
- Reset, then lookup PC 0x100 -> `branch_decision=0`, `decision_valid=1` one cycle later, `lookup_count=1`.
- Update PC 0x100 taken twice, then lookup -> counter goes WNT→WT→ST and the lookup predicts 1. Three not-taken updates, then lookup -> SNT, prediction 0. A further not-taken update leaves it at SNT.
- Aliasing: ENTRIES=64, PCs 0x100 and 0x200 share idx 0. Training 0x100 taken twice makes a lookup of 0x200 predict 1. PC 0x104 (idx 1) still predicts 0.
- Same cycle: lookup 0x40 plus taken update 0x40 starting from WNT -> `branch_decision=1` (bypassed WT). Same stimulus with update PC 0x44 -> `branch_decision=0`.
- Statistics: preload `mispredict_count` to 0xFFFFFFFE via 0xFFFFFFFE mispredict updates (or a force), then apply 3 more -> the counter stays 0xFFFFFFFF. Updates with `upd_mispredict=0` do not change it.
- Async reset mid-stream: train entry 3 to ST and assert `rst_n=0` between edges -> `branch_decision`, `decision_valid` and both counters read 0 before the next edge. After release, a lookup of idx 3 predicts 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types, constants and helper functions for the branch predictor.
package bp_pkg;

    localparam int PC_W = 64;

    // 2-bit saturating counter; bit [1] is the taken/not-taken prediction.
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Every entry starts weakly not-taken.
    localparam ctr_t CTR_RESET = CTR_WNT;

    // Word address of a PC. The caller keeps only the low index bits,
    // so everything above the index aliases (no tags).
    function automatic logic [PC_W-3:0] bp_index(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:2];
    endfunction

    // One training step with exact saturation at both ends.
    function automatic ctr_t bp_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != CTR_ST) begin
                n = ctr_t'(c + 2'd1);
            end
        end else begin
            if (c != CTR_SNT) begin
                n = ctr_t'(c - 2'd1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Statistics counter that counts enabled cycles and sticks at all-ones.
module bp_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// PC-indexed table of 2-bit saturating counters producing a registered
// taken/not-taken decision, trained by resolved branches, with saturating
// lookup and mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              branch_decision,
    output logic              decision_valid,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] lookup_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [PC_W-3:0]  pred_word;
    logic [PC_W-3:0]  upd_word;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_idx_bits;

    // Flop array rather than RAM so every entry can be cleared asynchronously.
    ctr_t pht_q [ENTRIES];
    ctr_t pht_d [ENTRIES];

    logic decision_q;
    logic decision_d;
    logic valid_q;
    logic valid_d;

    assign pred_word = bp_index(pred_pc);
    assign upd_word  = bp_index(upd_pc);
    assign pred_idx  = pred_word[IDX_W-1:0];
    assign upd_idx   = upd_word[IDX_W-1:0];

    // PC bits above the index are deliberately ignored; aliasing is allowed.
    assign unused_idx_bits = ^{pred_word[PC_W-3:IDX_W], upd_word[PC_W-3:IDX_W]};

    // Train the addressed entry; all other entries hold.
    always_comb begin
        pht_d = pht_q;
        if (upd_valid) begin
            pht_d[upd_idx] = bp_next(pht_q[upd_idx], upd_taken);
        end
    end

    // Read the post-update table so a same-index update in this cycle is bypassed.
    always_comb begin
        decision_d = decision_q;
        valid_d    = pred_valid;
        if (pred_valid) begin
            decision_d = pht_d[pred_idx][1];
        end
    end

    // Table and decision registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CTR_RESET;
            end
            decision_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            pht_q      <= pht_d;
            decision_q <= decision_d;
            valid_q    <= valid_d;
        end
    end

    assign branch_decision = decision_q;
    assign decision_valid  = valid_q;

    bp_sat_counter #(
        .WIDTH (STAT_W)
    ) u_lookup_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pred_valid),
        .count (lookup_count)
    );

    bp_sat_counter #(
        .WIDTH (STAT_W)
    ) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_valid & upd_mispredict),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: a default-sized instance for the
// prediction behaviour and a 4-entry, 4-bit-statistics instance for saturation.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst_n;

    // Main instance signals
    logic        pred_valid;
    logic [63:0] pred_pc;
    logic        branch_decision;
    logic        decision_valid;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] lookup_count;
    logic [31:0] mispredict_count;

    // Small instance signals
    logic        s_pred_valid;
    logic [63:0] s_pred_pc;
    logic        s_branch_decision;
    logic        s_decision_valid;
    logic        s_upd_valid;
    logic [63:0] s_upd_pc;
    logic        s_upd_taken;
    logic        s_upd_mispredict;
    logic [3:0]  s_lookup_count;
    logic [3:0]  s_mispredict_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_lookups;
    logic [31:0] exp_mispredicts;

    // 10-time-unit clock
    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .branch_decision  (branch_decision),
        .decision_valid   (decision_valid),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .lookup_count     (lookup_count),
        .mispredict_count (mispredict_count)
    );

    branch_predictor #(
        .ENTRIES (4),
        .STAT_W  (4)
    ) dut_small (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (s_pred_valid),
        .pred_pc          (s_pred_pc),
        .branch_decision  (s_branch_decision),
        .decision_valid   (s_decision_valid),
        .upd_valid        (s_upd_valid),
        .upd_pc           (s_upd_pc),
        .upd_taken        (s_upd_taken),
        .upd_mispredict   (s_upd_mispredict),
        .lookup_count     (s_lookup_count),
        .mispredict_count (s_mispredict_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle on the main instance, then sample 1 unit after the edge.
    task automatic applyStimulus(input logic pv, input logic [63:0] ppc,
                                 input logic uv, input logic [63:0] upc,
                                 input logic ut, input logic um);
        pred_valid     = pv;
        pred_pc        = ppc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_mispredict = um;
        @(posedge clk);
        #1;
        if (pv) exp_lookups++;
        if (uv && um) exp_mispredicts++;
    endtask

    // Drive one cycle on the small instance.
    task automatic applySmall(input logic pv, input logic [63:0] ppc,
                              input logic uv, input logic [63:0] upc,
                              input logic ut, input logic um);
        s_pred_valid     = pv;
        s_pred_pc        = ppc;
        s_upd_valid      = uv;
        s_upd_pc         = upc;
        s_upd_taken      = ut;
        s_upd_mispredict = um;
        @(posedge clk);
        #1;
    endtask

    task automatic doLookup(input logic [63:0] pc);
        applyStimulus(1'b1, pc, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic doUpdate(input logic [63:0] pc, input logic taken, input logic misp);
        applyStimulus(1'b0, 64'h0, 1'b1, pc, taken, misp);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    // Lookup and check the resulting decision with its valid flag.
    task automatic lookupExpect(input string tag, input logic [63:0] pc, input logic exp_dec);
        doLookup(pc);
        checkOutput({tag, "_dec"}, 64'(branch_decision), 64'(exp_dec));
        checkOutput({tag, "_vld"}, 64'(decision_valid), 64'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        pred_valid      = 1'b0;
        pred_pc         = '0;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_mispredict  = 1'b0;
        s_pred_valid    = 1'b0;
        s_pred_pc       = '0;
        s_upd_valid     = 1'b0;
        s_upd_pc        = '0;
        s_upd_taken     = 1'b0;
        s_upd_mispredict = 1'b0;
        exp_lookups     = 32'd0;
        exp_mispredicts = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dec", 64'(branch_decision), 64'd0);
        checkOutput("rst_vld", 64'(decision_valid), 64'd0);
        checkOutput("rst_lookups", 64'(lookup_count), 64'd0);
        checkOutput("rst_mispredicts", 64'(mispredict_count), 64'd0);
        checkOutput("rst_small_mispredicts", 64'(s_mispredict_count), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // First lookup after reset predicts WNT -> not taken
        lookupExpect("first_lookup", 64'h100, 1'b0);
        checkOutput("first_lookup_count", 64'(lookup_count), 64'd1);

        // No lookup: valid drops, decision holds
        doIdle();
        checkOutput("idle_vld", 64'(decision_valid), 64'd0);
        checkOutput("idle_dec_hold0", 64'(branch_decision), 64'd0);

        // Back-to-back taken updates: WNT -> WT -> ST
        doUpdate(64'h100, 1'b1, 1'b1);
        doUpdate(64'h100, 1'b1, 1'b0);
        lookupExpect("after_tt", 64'h100, 1'b1);
        doIdle();
        checkOutput("idle_dec_hold1", 64'(branch_decision), 64'd1);
        checkOutput("idle_vld2", 64'(decision_valid), 64'd0);
        checkOutput("mispredicts_1", 64'(mispredict_count), 64'd1);
        checkOutput("lookups_2", 64'(lookup_count), 64'd2);

        // ST -> WT still predicts taken
        doUpdate(64'h100, 1'b0, 1'b1);
        lookupExpect("st_n_wt", 64'h100, 1'b1);
        // WT -> WNT -> SNT
        doUpdate(64'h100, 1'b0, 1'b0);
        doUpdate(64'h100, 1'b0, 1'b0);
        lookupExpect("to_snt", 64'h100, 1'b0);
        // SNT stays SNT, so one taken reaches only WNT, a second reaches WT
        doUpdate(64'h100, 1'b0, 1'b1);
        doUpdate(64'h100, 1'b1, 1'b0);
        lookupExpect("snt_sat_then_t", 64'h100, 1'b0);
        doUpdate(64'h100, 1'b1, 1'b0);
        lookupExpect("snt_sat_then_tt", 64'h100, 1'b1);
        // WT -> ST -> ST -> ST, then one not-taken lands on WT
        doUpdate(64'h100, 1'b1, 1'b0);
        doUpdate(64'h100, 1'b1, 1'b0);
        doUpdate(64'h100, 1'b1, 1'b0);
        doUpdate(64'h100, 1'b0, 1'b0);
        lookupExpect("st_sat_then_n", 64'h100, 1'b1);

        // Aliasing: 0x200 shares idx 0 with 0x100; 0x104 is idx 1
        doUpdate(64'h100, 1'b1, 1'b0);
        lookupExpect("alias_0x200", 64'h200, 1'b1);
        lookupExpect("idx1_0x104", 64'h104, 1'b0);

        // Same-cycle lookup and update
        applyStimulus(1'b1, 64'h40, 1'b1, 64'h40, 1'b1, 1'b0);
        checkOutput("bypass_same_idx", 64'(branch_decision), 64'd1);
        applyStimulus(1'b1, 64'h80, 1'b1, 64'h84, 1'b1, 1'b0);
        checkOutput("diff_idx", 64'(branch_decision), 64'd0);
        lookupExpect("diff_idx_trained", 64'h84, 1'b1);
        applyStimulus(1'b1, 64'h40, 1'b1, 64'h40, 1'b0, 1'b0);
        checkOutput("bypass_not_taken", 64'(branch_decision), 64'd0);

        checkOutput("lookups_model", 64'(lookup_count), 64'(exp_lookups));
        checkOutput("mispredicts_model", 64'(mispredict_count), 64'(exp_mispredicts));

        // Async reset between edges
        doUpdate(64'hC, 1'b1, 1'b1);
        doUpdate(64'hC, 1'b1, 1'b0);
        lookupExpect("idx3_st", 64'hC, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_dec", 64'(branch_decision), 64'd0);
        checkOutput("async_rst_vld", 64'(decision_valid), 64'd0);
        checkOutput("async_rst_lookups", 64'(lookup_count), 64'd0);
        checkOutput("async_rst_mispredicts", 64'(mispredict_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_lookups     = 32'd0;
        exp_mispredicts = 32'd0;
        lookupExpect("post_rst_idx3", 64'hC, 1'b0);
        checkOutput("post_rst_lookups", 64'(lookup_count), 64'd1);

        // Small instance: 4 entries, 4-bit statistics
        for (int i = 0; i < 14; i++) begin
            applySmall(1'b0, 64'h0, 1'b1, 64'h10, 1'b1, 1'b1);
        end
        checkOutput("small_misp_14", 64'(s_mispredict_count), 64'hE);
        for (int i = 0; i < 3; i++) begin
            applySmall(1'b0, 64'h0, 1'b1, 64'h10, 1'b1, 1'b1);
        end
        checkOutput("small_misp_sat", 64'(s_mispredict_count), 64'hF);
        applySmall(1'b0, 64'h0, 1'b1, 64'h10, 1'b0, 1'b0);
        checkOutput("small_misp_nomisp", 64'(s_mispredict_count), 64'hF);
        // 0x10 aliases idx 0 when ENTRIES=4; trained to ST then one not-taken -> WT
        applySmall(1'b1, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("small_alias_dec", 64'(s_branch_decision), 64'd1);
        applySmall(1'b1, 64'h4, 1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("small_idx1_dec", 64'(s_branch_decision), 64'd0);
        checkOutput("small_lookups_2", 64'(s_lookup_count), 64'd2);
        for (int i = 0; i < 16; i++) begin
            applySmall(1'b1, 64'h8, 1'b0, 64'h0, 1'b0, 1'b0);
        end
        checkOutput("small_lookups_sat", 64'(s_lookup_count), 64'hF);
        applySmall(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
